multi_ch_timer_out: RTL and testbench

- N-channel programmable timer/waveform generator; successor to the single-channel threshold toggle counter.
- Each channel has its own counter, period, duty and mode: toggle, tick pulse, PWM or one-shot.
- Sits between PS-written control registers (AXI-lite regfile) and PL outputs (LEDs, GPIO, strobes to other PL blocks).
- All outputs registered.

---
 rtl/multi_ch_timer_out_if.sv | 38 +++
 rtl/multi_ch_timer_out.sv | 116 +++++++++++
 tb/tb_multi_ch_timer_out.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/multi_ch_timer_out_if.sv
// Control/status bundle between the regfile side and multi_ch_timer_out.
// With OUT_INV_EN defined the bundle also carries the per-channel i_invert level.
interface multi_ch_timer_out_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
);
  logic [NUM_CH-1:0]       i_enable;
  logic [2*NUM_CH-1:0]     i_mode;
  logic [CNT_W*NUM_CH-1:0] i_period;
  logic [CNT_W*NUM_CH-1:0] i_duty;
  logic [NUM_CH-1:0]       i_start;
`ifdef OUT_INV_EN
  logic [NUM_CH-1:0]       i_invert;
`endif
  logic [NUM_CH-1:0]       o_out;
  logic [NUM_CH-1:0]       o_tick;
  logic [NUM_CH-1:0]       o_busy;

`ifdef OUT_INV_EN
  modport master (
    output i_enable, i_mode, i_period, i_duty, i_start, i_invert,
    input  o_out, o_tick, o_busy
  );
  modport slave (
    input  i_enable, i_mode, i_period, i_duty, i_start, i_invert,
    output o_out, o_tick, o_busy
  );
`else
  modport master (
    output i_enable, i_mode, i_period, i_duty, i_start,
    input  o_out, o_tick, o_busy
  );
  modport slave (
    input  i_enable, i_mode, i_period, i_duty, i_start,
    output o_out, o_tick, o_busy
  );
`endif
endinterface

// File: rtl/multi_ch_timer_out.sv
// N-channel timer/waveform generator: per-channel TOGGLE, PULSE, PWM or ONESHOT.
// Optional macro OUT_INV_EN adds a per-channel output inversion (i_invert).
module multi_ch_timer_out #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
) (
  input logic                 clk,
  input logic                 reset_n,
  multi_ch_timer_out_if.slave tmr
);
  localparam logic [1:0] M_TOGGLE  = 2'd0;
  localparam logic [1:0] M_PULSE   = 2'd1;
  localparam logic [1:0] M_PWM     = 2'd2;
  localparam logic [1:0] M_ONESHOT = 2'd3;

  typedef enum logic {OS_IDLE, OS_RUN} os_state_t;

  logic [CNT_W-1:0]  cnt_q    [NUM_CH];
  logic [CNT_W-1:0]  cnt_nx   [NUM_CH];
  logic [1:0]        mode_q   [NUM_CH];
  logic [1:0]        mode_c   [NUM_CH];
  os_state_t         os_q     [NUM_CH];
  logic [NUM_CH-1:0] wrap;
  logic [NUM_CH-1:0] wave_run;
  logic [NUM_CH-1:0] wave_q;
  logic [NUM_CH-1:0] out_q;
  logic [NUM_CH-1:0] tick_q;
  logic [NUM_CH-1:0] busy_q;
  logic [NUM_CH-1:0] inv;

`ifdef OUT_INV_EN
  assign inv = tmr.i_invert;
`else
  assign inv = '0;
`endif

  function automatic logic pwm_level(input logic [CNT_W-1:0] cnt_n,
                                     input logic [CNT_W-1:0] duty);
    return cnt_n < duty;
  endfunction

  // Wrap uses >= so a period lowered below the running count wraps on the next edge.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      mode_c[c] = tmr.i_mode[2*c +: 2];
      wrap[c]   = cnt_q[c] >= tmr.i_period[CNT_W*c +: CNT_W];
      cnt_nx[c] = wrap[c] ? '0 : cnt_q[c] + CNT_W'(1);
      case (mode_c[c])
        M_TOGGLE: wave_run[c] = wave_q[c] ^ wrap[c];
        M_PULSE:  wave_run[c] = wrap[c];
        M_PWM:    wave_run[c] = pwm_level(cnt_nx[c], tmr.i_duty[CNT_W*c +: CNT_W]);
        default:  wave_run[c] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_q[c]  <= '0;
        mode_q[c] <= M_TOGGLE;
        os_q[c]   <= OS_IDLE;
      end
      wave_q <= '0;
      out_q  <= '0;
      tick_q <= '0;
      busy_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        mode_q[c] <= mode_c[c];
        tick_q[c] <= 1'b0;
        if (!tmr.i_enable[c]) begin
          cnt_q[c]  <= '0;
          wave_q[c] <= 1'b0;
          out_q[c]  <= inv[c];
          busy_q[c] <= 1'b0;
          os_q[c]   <= OS_IDLE;
        end else if (mode_c[c] != mode_q[c]) begin
          // Mode switch restarts the channel from a clean period.
          cnt_q[c]  <= '0;
          wave_q[c] <= 1'b0;
          out_q[c]  <= inv[c];
          busy_q[c] <= (mode_c[c] != M_ONESHOT);
          os_q[c]   <= OS_IDLE;
        end else if (mode_c[c] == M_ONESHOT) begin
          if (os_q[c] == OS_IDLE) begin
            cnt_q[c]  <= '0;
            wave_q[c] <= tmr.i_start[c];
            out_q[c]  <= tmr.i_start[c] ^ inv[c];
            busy_q[c] <= tmr.i_start[c];
            os_q[c]   <= tmr.i_start[c] ? OS_RUN : OS_IDLE;
          end else begin
            cnt_q[c]  <= cnt_nx[c];
            tick_q[c] <= wrap[c];
            wave_q[c] <= ~wrap[c];
            out_q[c]  <= ~wrap[c] ^ inv[c];
            busy_q[c] <= ~wrap[c];
            os_q[c]   <= wrap[c] ? OS_IDLE : OS_RUN;
          end
        end else begin
          cnt_q[c]  <= cnt_nx[c];
          tick_q[c] <= wrap[c];
          wave_q[c] <= wave_run[c];
          out_q[c]  <= wave_run[c] ^ inv[c];
          busy_q[c] <= 1'b1;
          os_q[c]   <= OS_IDLE;
        end
      end
    end
  end

  assign tmr.o_out  = out_q;
  assign tmr.o_tick = tick_q;
  assign tmr.o_busy = busy_q;

endmodule

// File: tb/tb_multi_ch_timer_out.sv
// Randomized + scenario bench for multi_ch_timer_out against a per-channel behavioural model.
`timescale 1ns/1ps
module tb_multi_ch_timer_out;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  multi_ch_timer_out_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();
  multi_ch_timer_out #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .tmr(bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Model state: position within the period, last seen mode, one-shot activity.
  longint            m_pos  [NUM_CH];
  int                m_prev [NUM_CH];
  bit                m_wave [NUM_CH];
  bit                m_run  [NUM_CH];
  logic [NUM_CH-1:0] m_out, m_tick, m_busy;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_pos[c] = 0; m_prev[c] = 0; m_wave[c] = 0; m_run[c] = 0;
    end
    m_out = '0; m_tick = '0; m_busy = '0;
  endtask

  task automatic model_edge();
    for (int c = 0; c < NUM_CH; c++) begin
      bit     en, wrap, iv;
      int     md;
      longint p, d;
      en   = bus.i_enable[c];
      md   = int'(bus.i_mode[2*c +: 2]);
      p    = longint'(bus.i_period[CNT_W*c +: CNT_W]);
      d    = longint'(bus.i_duty[CNT_W*c +: CNT_W]);
`ifdef OUT_INV_EN
      iv   = bus.i_invert[c];
`else
      iv   = 1'b0;
`endif
      wrap = 1'b0;
      if (!en) begin
        m_pos[c] = 0; m_wave[c] = 0; m_run[c] = 0; m_busy[c] = 0;
      end else if (md != m_prev[c]) begin
        m_pos[c] = 0; m_wave[c] = 0; m_run[c] = 0; m_busy[c] = (md != 3);
      end else if (md == 3 && !m_run[c]) begin
        m_pos[c]  = 0;
        m_run[c]  = bus.i_start[c];
        m_wave[c] = bus.i_start[c];
        m_busy[c] = bus.i_start[c];
      end else begin
        wrap = (m_pos[c] >= p);
        m_pos[c] = wrap ? 0 : m_pos[c] + 1;
        if (md == 0)      m_wave[c] = m_wave[c] ^ wrap;
        else if (md == 1) m_wave[c] = wrap;
        else if (md == 2) m_wave[c] = (m_pos[c] < d);
        else begin
          if (wrap) m_run[c] = 0;
          m_wave[c] = m_run[c];
        end
        m_busy[c] = (md == 3) ? m_run[c] : 1'b1;
      end
      m_prev[c] = md;
      m_tick[c] = wrap;
      m_out[c]  = m_wave[c] ^ iv;
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      if (reset_n) model_edge(); else model_reset();
      #1;
      cyc++;
      check_eq("o_out",  64'(bus.o_out),  64'(m_out));
      check_eq("o_tick", 64'(bus.o_tick), 64'(m_tick));
      check_eq("o_busy", 64'(bus.o_busy), 64'(m_busy));
    end
  endtask

  task automatic set_ch(input int c, input bit en, input int md, input int p, input int d);
    bus.i_enable[c]                = en;
    bus.i_mode[2*c +: 2]           = md[1:0];
    bus.i_period[CNT_W*c +: CNT_W] = CNT_W'(p);
    bus.i_duty[CNT_W*c +: CNT_W]   = CNT_W'(d);
  endtask

  initial begin
    int hi, tk;
    bus.i_enable = '0; bus.i_mode = '0; bus.i_period = '0;
    bus.i_duty = '0; bus.i_start = '0;
`ifdef OUT_INV_EN
    bus.i_invert = '0;
`endif
    model_reset();
    step(3);
    check_eq("rst_out",  64'(bus.o_out),  64'(0));
    check_eq("rst_busy", 64'(bus.o_busy), 64'(0));
    #2 reset_n = 1'b1;

    // Asynchronous reset in the middle of a TOGGLE run, then first toggle on edge 6.
    set_ch(0, 1, 0, 5, 0);
    step(20);
    reset_n = 1'b0;
    #1;
    check_eq("arst_out",  64'(bus.o_out),  64'(0));
    check_eq("arst_tick", 64'(bus.o_tick), 64'(0));
    check_eq("arst_busy", 64'(bus.o_busy), 64'(0));
    model_reset();
    step(2);
    #2 reset_n = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      step(1);
      check_eq("tog_first", 64'(bus.o_out[0]), 64'(e == 6));
    end
    set_ch(0, 0, 0, 0, 0);

    // TOGGLE P=3 then P=0 on channel 1.
    set_ch(1, 1, 0, 3, 0);
    step(17);
    set_ch(1, 1, 0, 0, 0);
    step(6);
    check_eq("p0_tick", 64'(bus.o_tick[1]), 64'(1));
    set_ch(1, 0, 0, 0, 0);

    // PWM P=9 on channel 2: D=3, D=0, D=10, then D 3->7 mid-period.
    set_ch(2, 1, 2, 9, 3);
    step(12);
    hi = 0;
    for (int k = 0; k < 10; k++) begin step(1); hi += bus.o_out[2]; end
    check_eq("pwm_d3_high", 64'(hi), 64'(3));
    set_ch(2, 1, 2, 9, 0);  step(12);
    set_ch(2, 1, 2, 9, 10); step(12);
    set_ch(2, 1, 2, 9, 3);  step(14);
    set_ch(2, 1, 2, 9, 7);  step(15);
    set_ch(2, 0, 0, 0, 0);

    // ONESHOT P=4 on channel 3: single shot, ignored retrigger, held start.
    set_ch(3, 1, 3, 4, 0);
    step(3);
    bus.i_start[3] = 1'b1; step(1); bus.i_start[3] = 1'b0;
    hi = bus.o_out[3]; tk = 0;
    for (int k = 0; k < 11; k++) begin step(1); hi += bus.o_out[3]; tk += bus.o_tick[3]; end
    check_eq("os_high", 64'(hi), 64'(5));
    check_eq("os_tick", 64'(tk), 64'(1));
    bus.i_start[3] = 1'b1; step(1); bus.i_start[3] = 1'b0;
    step(2);
    bus.i_start[3] = 1'b1; step(1); bus.i_start[3] = 1'b0;
    step(8);
    bus.i_start[3] = 1'b1; step(18); bus.i_start[3] = 1'b0;
    set_ch(3, 0, 0, 0, 0);
    step(1);

    // Boundaries on channel 0: period lowered below count, disable mid-period, mode change.
    set_ch(0, 1, 0, 20, 0);
    step(12);
    set_ch(0, 1, 0, 5, 0);
    step(1);
    check_eq("plow_tick", 64'(bus.o_tick[0]), 64'(1));
    step(4);
    bus.i_enable[0] = 1'b0;
    step(1);
    check_eq("dis_out",  64'(bus.o_out[0]),  64'(0));
    check_eq("dis_busy", 64'(bus.o_busy[0]), 64'(0));
    bus.i_enable[0] = 1'b1;
    step(9);
    set_ch(0, 1, 2, 5, 2);
    step(10);

    // All four channels concurrently with distinct modes and periods.
    set_ch(0, 1, 0, 3, 0);
    set_ch(1, 1, 1, 7, 0);
    set_ch(2, 1, 2, 0, 1);
    set_ch(3, 1, 3, 15, 0);
    bus.i_start[3] = 1'b1;
    step(60);
    bus.i_start = '0;

`ifdef OUT_INV_EN
    bus.i_enable = '0;
    bus.i_invert = 4'b0101;
    step(2);
    check_eq("inv_idle", 64'(bus.o_out), 64'(4'b0101));
`endif

    // Randomized configuration churn.
    for (int k = 0; k < 1500; k++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(39) == 0)
          set_ch(c, ($urandom_range(7) != 0), int'($urandom_range(3)),
                 int'($urandom_range(12)), int'($urandom_range(14)));
        bus.i_start[c] = ($urandom_range(3) == 0);
      end
`ifdef OUT_INV_EN
      if ($urandom_range(99) == 0) bus.i_invert = NUM_CH'($urandom);
`endif
      step(1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
